// File: rtl/redun_mont_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : redun_mont_pkg
//  Description : Shared types and constants for the redundant-form Montgomery
//                squaring core and its run sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package redun_mont_pkg;

   // Redundant-form operand: NUM_WRDS words, each WRD_BITS plus one carry bit
   localparam int WRD_BITS = 16;
   localparam int NUM_WRDS = 4;
   typedef logic [NUM_WRDS-1:0][WRD_BITS:0] redun0_t;

   // Default iteration-count width
   localparam int DEF_ITER_BITS = 64;
   typedef logic [DEF_ITER_BITS-1:0] iter_t;

   // Default core-stop reset length and checkpoint period
   localparam int DEF_CORE_RST_CYC = 4;
   localparam int DEF_CKPT_LOG2    = 20;

   // Sequencer states, explicit 3-bit encoding
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      RUN    = 3'd2,
      STOP   = 3'd3,
      DONE   = 3'd4
   } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/redun_mont_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : redun_mont_seq_ctrl_if
//  Description : Host-side request/result bundle of the Montgomery squaring
//                sequencer. master = host, slave = sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface redun_mont_seq_ctrl_if
   import redun_mont_pkg::*;
#(
   parameter int ITER_BITS = DEF_ITER_BITS
);
   logic                 i_start;
   redun0_t              i_sq;
   logic [ITER_BITS-1:0] i_iters;
   logic                 i_abort;
   logic                 i_ack;
   logic                 o_busy;
   logic                 o_done;
   logic                 o_err;
   redun0_t              o_result;

   modport master (
      output i_start, i_sq, i_iters, i_abort, i_ack,
      input  o_busy, o_done, o_err, o_result
   );

   modport slave (
      input  i_start, i_sq, i_iters, i_abort, i_ack,
      output o_busy, o_done, o_err, o_result
   );
endinterface
`default_nettype wire

// File: rtl/redun_mont_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : redun_mont_seq_ctrl
//  Description : Run sequencer for the redundant-form Montgomery squaring
//                core. Launches the core once, counts T squaring pulses,
//                captures the T-th result, stops the core by holding its
//                reset, and hands the result to the host via done/ack.
//                Optional checkpoint outputs: REDUN_MONT_CKPT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module redun_mont_seq_ctrl
   import redun_mont_pkg::*;
#(
   parameter int ITER_BITS    = DEF_ITER_BITS,
   parameter int CORE_RST_CYC = DEF_CORE_RST_CYC
`ifdef REDUN_MONT_CKPT_EN
   ,
   parameter int CKPT_LOG2    = DEF_CKPT_LOG2
`endif
)(
   input  wire logic                 i_clk,
   input  wire logic                 i_rst,
   redun_mont_seq_ctrl_if.slave      host,
   output      logic                 o_core_rst,
   output      redun0_t              o_core_sq,
   output      logic                 o_core_val,
   input  wire redun0_t              i_core_mul,
   input  wire logic                 i_core_val,
   input  wire logic                 i_core_ovf
`ifdef REDUN_MONT_CKPT_EN
   ,
   output      logic                 o_ckpt_val,
   output      redun0_t              o_ckpt
`endif
);

   // Stop counter wide enough to hold CORE_RST_CYC-1
   localparam int C_STOP_W = (CORE_RST_CYC > 1) ? $clog2(CORE_RST_CYC) : 1;

   seq_state_t           r_state;
   seq_state_t           w_state_nxt;
   logic [ITER_BITS-1:0] r_cnt;
   logic [ITER_BITS-1:0] r_iters;
   logic [C_STOP_W-1:0]  r_stop_cnt;
   logic                 r_abort;
   logic                 r_err;
   redun0_t              r_result;
   redun0_t              r_core_sq;

   logic                 w_last;
   logic                 w_stop_end;
   logic                 w_busy;
   logic                 w_done;
   logic                 w_core_val;
   logic                 w_stopping;

   // Final squaring pulse: cnt has reached T-1 (T>0 guaranteed once running)
   assign w_last     = i_core_val && (r_cnt == (r_iters - ITER_BITS'(1)));
   assign w_stop_end = (r_stop_cnt == C_STOP_W'(CORE_RST_CYC - 1));

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic; abort has priority over the final result pulse
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (host.i_start)
                     w_state_nxt = (host.i_iters == '0) ? DONE : LAUNCH;
         LAUNCH:  w_state_nxt = host.i_abort ? STOP : RUN;
         RUN:     if (host.i_abort || w_last) w_state_nxt = STOP;
         STOP:    if (w_stop_end) w_state_nxt = r_abort ? IDLE : DONE;
         DONE:    if (host.i_ack) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      w_busy     = 1'b0;
      w_done     = 1'b0;
      w_core_val = 1'b0;
      w_stopping = 1'b0;
      case (r_state)
         LAUNCH:  begin w_busy = 1'b1; w_core_val = 1'b1; end
         RUN:     w_busy = 1'b1;
         STOP:    begin w_busy = 1'b1; w_stopping = 1'b1; end
         DONE:    w_done = 1'b1;
         default: ;
      endcase
   end

   // Run datapath: request latch, squaring counter, sticky error, result
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt      <= '0;
         r_iters    <= '0;
         r_stop_cnt <= '0;
         r_abort    <= 1'b0;
         r_err      <= 1'b0;
         r_result   <= '0;
         r_core_sq  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (host.i_start) begin
                  r_core_sq  <= host.i_sq;
                  r_iters    <= host.i_iters;
                  r_cnt      <= '0;
                  r_err      <= 1'b0;
                  r_abort    <= 1'b0;
                  r_stop_cnt <= '0;
                  if (host.i_iters == '0) r_result <= host.i_sq;
               end
            end
            LAUNCH: begin
               if (i_core_ovf)   r_err   <= 1'b1;
               if (host.i_abort) r_abort <= 1'b1;
            end
            RUN: begin
               if (i_core_ovf) r_err <= 1'b1;
               if (host.i_abort) begin
                  r_abort <= 1'b1;
               end else if (i_core_val) begin
                  r_cnt <= r_cnt + ITER_BITS'(1);
                  if (w_last) r_result <= i_core_mul;
               end
            end
            STOP: begin
               if (w_stop_end) r_stop_cnt <= '0;
               else            r_stop_cnt <= r_stop_cnt + C_STOP_W'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef REDUN_MONT_CKPT_EN
   logic [CKPT_LOG2-1:0] w_ckpt_phase;
   logic                 w_ckpt_hit;

   assign w_ckpt_phase = r_cnt[CKPT_LOG2-1:0] + CKPT_LOG2'(1);
   assign w_ckpt_hit   = (r_state == RUN) && i_core_val && (w_ckpt_phase == '0);

   // Checkpoint capture on every 2^CKPT_LOG2-th squaring
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_ckpt_val <= 1'b0;
         o_ckpt     <= '0;
      end else begin
         o_ckpt_val <= w_ckpt_hit;
         if (w_ckpt_hit) o_ckpt <= i_core_mul;
      end
   end
`endif

   assign host.o_busy   = w_busy;
   assign host.o_done   = w_done;
   assign host.o_err    = r_err;
   assign host.o_result = r_result;
   assign o_core_rst    = i_rst | w_stopping;
   assign o_core_sq     = r_core_sq;
   assign o_core_val    = w_core_val;

endmodule
`default_nettype wire

// File: tb/tb_redun_mont_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_redun_mont_seq_ctrl
//  Description : Directed self-checking bench for redun_mont_seq_ctrl with a
//                behavioural squaring core (x -> x^2 * R^-1 mod 23, R = 32).
//                Orbit from 3: 3,1,18,13,6,4,12,16,8,2,3,... (period 10).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_redun_mont_seq_ctrl;
   import redun_mont_pkg::*;

   localparam int ITER_BITS    = 8;
   localparam int CORE_RST_CYC = 4;
`ifdef REDUN_MONT_CKPT_EN
   localparam int CKPT_LOG2    = 1;
`endif

   logic    clk = 1'b0;
   logic    rst;
   logic    core_rst;
   logic    core_val;
   redun0_t core_sq;
   logic    cval;
   redun0_t cmul;
   logic    covf;
`ifdef REDUN_MONT_CKPT_EN
   logic    ckpt_val;
   redun0_t ckpt;
   redun0_t ckpt_q[$];
`endif

   int n_checks = 0;
   int n_errors = 0;
   int n_launch = 0;
   int n_pulse  = 0;

   always #5 clk = ~clk;

   redun_mont_seq_ctrl_if #(.ITER_BITS(ITER_BITS)) host_if ();

   redun_mont_seq_ctrl #(
      .ITER_BITS    (ITER_BITS),
      .CORE_RST_CYC (CORE_RST_CYC)
`ifdef REDUN_MONT_CKPT_EN
      ,
      .CKPT_LOG2    (CKPT_LOG2)
`endif
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .host       (host_if),
      .o_core_rst (core_rst),
      .o_core_sq  (core_sq),
      .o_core_val (core_val),
      .i_core_mul (cmul),
      .i_core_val (cval),
      .i_core_ovf (covf)
`ifdef REDUN_MONT_CKPT_EN
      ,
      .o_ckpt_val (ckpt_val),
      .o_ckpt     (ckpt)
`endif
   );

   function automatic logic [WRD_BITS:0] msq(input logic [WRD_BITS:0] x);
      int unsigned v;
      v = 32'(x) % 32'd23;
      v = (v * v * 32'd18) % 32'd23;
      return (WRD_BITS+1)'(v);
   endfunction

   function automatic redun0_t mk(input int unsigned w0, input int unsigned w1);
      redun0_t r;
      r    = '0;
      r[0] = (WRD_BITS+1)'(w0);
      r[1] = (WRD_BITS+1)'(w1);
      return r;
   endfunction

   // Behavioural core: after launch, one squaring pulse every two cycles
   logic              run;
   logic              dly;
   logic [WRD_BITS:0] x;
   always @(posedge clk) begin
      if (core_rst) begin
         run  <= 1'b0;
         dly  <= 1'b0;
         cval <= 1'b0;
         cmul <= '0;
         x    <= '0;
      end else begin
         cval <= 1'b0;
         if (core_val) begin
            run <= 1'b1;
            dly <= 1'b0;
            x   <= core_sq[0];
         end else if (run) begin
            if (dly) begin
               dly  <= 1'b0;
               cval <= 1'b1;
               x    <= msq(x);
               cmul <= mk(32'(msq(x)), 0);
            end else begin
               dly <= 1'b1;
            end
         end
      end
   end

   // Event counters sampled mid-cycle
   always @(negedge clk) begin
      if (!rst && core_val) n_launch <= n_launch + 1;
      if (!core_rst && cval) n_pulse <= n_pulse + 1;
`ifdef REDUN_MONT_CKPT_EN
      if (!rst && ckpt_val) ckpt_q.push_back(ckpt);
`endif
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input redun0_t sq, input int unsigned t);
      host_if.i_start = 1'b1;
      host_if.i_sq    = sq;
      host_if.i_iters = ITER_BITS'(t);
      tick();
      host_if.i_start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!host_if.o_done && n < 2000) begin
         tick();
         n++;
      end
      check(tag, 128'(host_if.o_done), 128'(1));
   endtask

   task automatic wait_pulses(input int base, input int cnt);
      int n;
      n = 0;
      while ((n_pulse - base) < cnt && n < 200) begin
         tick();
         n++;
      end
      check("pulse_wait", 128'((n_pulse - base) >= cnt), 128'(1));
   endtask

   task automatic ack();
      host_if.i_ack = 1'b1;
      tick();
      host_if.i_ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  l0;
      int  p0;
      int  rc;
      logic held;

      rst             = 1'b1;
      covf            = 1'b0;
      host_if.i_start = 1'b0;
      host_if.i_sq    = '0;
      host_if.i_iters = '0;
      host_if.i_abort = 1'b0;
      host_if.i_ack   = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_busy",     128'(host_if.o_busy),   128'(0));
      check("rst_done",     128'(host_if.o_done),   128'(0));
      check("rst_err",      128'(host_if.o_err),    128'(0));
      check("rst_result",   128'(host_if.o_result), 128'(0));
      check("rst_core_val", 128'(core_val),         128'(0));
      check("rst_core_sq",  128'(core_sq),          128'(0));
      check("rst_core_rst", 128'(core_rst),         128'(1));
      rst = 1'b0;
      tick();
      check("core_rst_rel", 128'(core_rst), 128'(0));

      // 1: sq=3, T=1 -> result 1, single launch pulse
      l0 = n_launch;
      start(mk(3, 0), 1);
      check("t1_busy_launch", 128'(host_if.o_busy), 128'(1));
      check("t1_core_val",    128'(core_val),       128'(1));
      check("t1_core_sq",     128'(core_sq),        128'(mk(3, 0)));
      wait_done("t1_done");
      check("t1_result",   128'(host_if.o_result), 128'(mk(1, 0)));
      check("t1_err",      128'(host_if.o_err),    128'(0));
      check("t1_busy",     128'(host_if.o_busy),   128'(0));
      check("t1_launches", 128'(n_launch - l0),    128'(1));
      ack();
      check("t1_ack_done", 128'(host_if.o_done), 128'(0));

      // 2: T=0 -> done next cycle, result = initial value, no launch
      l0 = n_launch;
      start(mk(3, 5), 0);
      check("t0_done",   128'(host_if.o_done),   128'(1));
      check("t0_result", 128'(host_if.o_result), 128'(mk(3, 5)));
      check("t0_busy",   128'(host_if.o_busy),   128'(0));
      ack();
      tick();
      check("t0_launches", 128'(n_launch - l0), 128'(0));

      // 3: abort after two squarings of a T=5 run
      p0 = n_pulse;
      start(mk(3, 0), 5);
      wait_pulses(p0, 2);
      host_if.i_abort = 1'b1;
      tick();
      host_if.i_abort = 1'b0;
      rc = 0;
      while (core_rst && rc < 20) begin
         rc++;
         tick();
      end
      check("ab_rst_cycles", 128'(rc),               128'(CORE_RST_CYC));
      check("ab_busy",       128'(host_if.o_busy),   128'(0));
      check("ab_done",       128'(host_if.o_done),   128'(0));
      check("ab_result",     128'(host_if.o_result), 128'(mk(3, 5)));
      start(mk(3, 0), 2);
      wait_done("ab_next_done");
      check("ab_next_result", 128'(host_if.o_result), 128'(mk(18, 0)));
      ack();

      // 4: ack withheld 10 cycles with start pulses; ack+start together
      start(mk(3, 0), 3);
      wait_done("hold_done");
      check("hold_result", 128'(host_if.o_result), 128'(mk(13, 0)));
      l0   = n_launch;
      held = 1'b1;
      for (int i = 0; i < 10; i++) begin
         host_if.i_start = (i == 3 || i == 6);
         host_if.i_iters = ITER_BITS'(1);
         tick();
         if (!host_if.o_done || host_if.o_busy) held = 1'b0;
      end
      host_if.i_start = 1'b0;
      check("hold_held",     128'(held),           128'(1));
      check("hold_launches", 128'(n_launch - l0),  128'(0));
      host_if.i_ack   = 1'b1;
      host_if.i_start = 1'b1;
      tick();
      host_if.i_ack   = 1'b0;
      host_if.i_start = 1'b0;
      check("hold_ack_done", 128'(host_if.o_done), 128'(0));
      check("hold_ack_busy", 128'(host_if.o_busy), 128'(0));
      check("hold_ack_cval", 128'(core_val),       128'(0));
      start(mk(2, 0), 1);
      wait_done("hold_next_done");
      check("hold_next_result", 128'(host_if.o_result), 128'(mk(3, 0)));
      ack();

      // 5: overflow during run, T=4
      p0 = n_pulse;
      start(mk(3, 0), 4);
      wait_pulses(p0, 1);
      covf = 1'b1;
      tick();
      covf = 1'b0;
      wait_done("ovf_done");
      check("ovf_err",    128'(host_if.o_err),    128'(1));
      check("ovf_result", 128'(host_if.o_result), 128'(mk(6, 0)));
      ack();
      start(mk(3, 0), 1);
      check("ovf_clr_err", 128'(host_if.o_err), 128'(0));
      wait_done("ovf_next_done");
      check("ovf_next_err",    128'(host_if.o_err),    128'(0));
      check("ovf_next_result", 128'(host_if.o_result), 128'(mk(1, 0)));
      ack();

      // 6: maximum count T=255 -> orbit index 255 mod 10 = 5 -> 4
      start(mk(3, 0), 255);
      wait_done("max_done");
      check("max_result", 128'(host_if.o_result), 128'(mk(4, 0)));
      ack();

      // 7: reset in the middle of a run
      start(mk(3, 0), 5);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      check("mrst_busy",     128'(host_if.o_busy),   128'(0));
      check("mrst_done",     128'(host_if.o_done),   128'(0));
      check("mrst_result",   128'(host_if.o_result), 128'(0));
      check("mrst_core_rst", 128'(core_rst),         128'(1));
      rst = 1'b0;
      tick();
      start(mk(3, 0), 1);
      wait_done("mrst_next_done");
      check("mrst_next_result", 128'(host_if.o_result), 128'(mk(1, 0)));
      ack();

`ifdef REDUN_MONT_CKPT_EN
      // 8: checkpoints every 2nd squaring, T=6 -> 18, 6, 12
      ckpt_q.delete();
      start(mk(3, 0), 6);
      wait_done("ckpt_done");
      tick();
      check("ckpt_result", 128'(host_if.o_result), 128'(mk(12, 0)));
      check("ckpt_count",  128'(ckpt_q.size()),    128'(3));
      if (ckpt_q.size() == 3) begin
         check("ckpt_0", 128'(ckpt_q[0]), 128'(mk(18, 0)));
         check("ckpt_1", 128'(ckpt_q[1]), 128'(mk(6, 0)));
         check("ckpt_2", 128'(ckpt_q[2]), 128'(mk(12, 0)));
      end
      ack();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
